enemy_walker_array: RTL and testbench
=====================================

Name: enemy_walker_array

Overview:
- Drives NUM_ENEMIES independent walking enemies (goomba class) on the 12x17 tile map.
- Each tick it moves each live enemy left or right by SPEED pixels, reverses on blocks and screen edges, and detects stomps and side contact against Mario.
- It keeps a stomp counter and raises a sticky global lose flag.
- Sits between the tile-map/background store and the renderer and game-state logic; it replaces the single-enemy mover.

Parameters:
NUM_ENEMIES, 4, number of enemy channels
CHARACTER_WIDTH, 42, enemy/Mario square sprite size in px
SCREEN_WIDTH, 640, screen width in px
BLOCK_WIDTH, 40, tile size in px
SPEED, 1, px moved per live tick (1..BLOCK_WIDTH-1)
BLK, 2, tile code that blocks movement
START_X, '{300,100,500,200}, per-channel reset x (int array, NUM_ENEMIES entries)
START_DIR, 4'b0101, per-channel reset direction bit (1=right)
OFFSCREEN_X, 1000, x written to dead enemies
COUNT_W, 8, stomp counter width

Ports:
movement_clock  in  1  movement tick clock
reset  in  1  asynchronous, active-low reset
enable  in  1  1=advance; 0=hold all state
background  in  byte[11:0][16:0]  tile map, indexed [row][col]
mario_x  in  int  Mario left px
mario_y  in  int  Mario top px
enemy_y  in  int[NUM_ENEMIES]  per-enemy top px (driven externally)
enemy_x  out  int[NUM_ENEMIES]  per-enemy left px
enemy_alive  out  NUM_ENEMIES  1=enemy live
lose  out  1  sticky: Mario touched a live enemy
stomp_count  out  COUNT_W  enemies stomped since reset, saturating

Behaviour:
- Reset (async, reset=0): enemy_x[i]=START_X[i]; dir[i]=START_DIR[i]; enemy_alive=all ones; lose=0; stomp_count=0. Every register is reset, outputs included.
- Per-channel state: WALK_L, WALK_R, DEAD. Global latch lose. All updates happen on posedge movement_clock, use the current registered values, and land one edge later.
- enable=0 or lose=1: no register changes (frozen).
- Geometry, per channel i, ex=enemy_x[i], ey=enemy_y[i], W=CHARACTER_WIDTH:
  - hov = (mario_x+W > ex) && (mario_x < ex+W)
  - stomp = hov && (mario_y+W == ey)
  - touch = hov && (mario_y+W > ey) && (mario_y < ey+W)
- Priority per live channel each edge: stomp > touch > wall > move.
  - stomp: state=DEAD; enemy_alive[i]=0; enemy_x[i]=OFFSCREEN_X; count +1.
  - touch: lose=1; the enemy does not move on that edge.
  - wall: flip dir; x unchanged on that edge.
  - otherwise x -= SPEED (WALK_L) or x += SPEED (WALK_R).
- Wall test. Rows are rt=ey/BLOCK_WIDTH and rb=(ey+W-1)/BLOCK_WIDTH.
  - WALK_L is blocked when ex < SPEED, or when background[rt][cl] or background[rb][cl] equals BLK, with cl=(ex-SPEED)/BLOCK_WIDTH.
  - WALK_R is blocked when ex+W+SPEED > SCREEN_WIDTH, or when the tile at cr=(ex+W-1+SPEED)/BLOCK_WIDTH in row rt or rb equals BLK.
  - Edge terms short-circuit: no map read when the edge term is true. Indices out of 0..11 / 0..16 count as not blocked.
- DEAD is terminal until reset. Dead channels never raise stomp or touch.
- Simultaneous events:
  - k stomps on one edge add k to the count, saturating at 2^COUNT_W-1.
  - Stomps and a touch on the same edge: the stomps are counted and the enemies killed, and lose is set on that same edge.
- Channels are independent. Enemy-enemy collision is not modelled.
- Reset mid-operation restores reset values immediately, regardless of clock.

Test Plan:
1. Reset, then 5 ticks, Mario far away (mario_x=0, mario_y=0), ch0 START_X=300, right, ey=400, empty map -> enemy_x[0]=305; ch1 (100, left)=95.
2. BLK at rows 10/11 col 9, ch0 right from 300, ey=400 -> x reaches 318, holds 318 one edge (reverse), then 317, 316.
3. ch1 left from x=2, SPEED=1 -> 1, 0, hold 0 (edge reverse), then 1.
4. Stomp: ch0 ex=300 ey=400, mario_x=280 mario_y=358 -> next edge enemy_alive[0]=0, enemy_x[0]=1000, stomp_count=1, lose=0; other channels keep moving.
5. Touch: mario_x=280 mario_y=380 vs ch0 -> lose=1; all enemy_x frozen on the following edges; a further stomp condition does not change the count.
6. Assert reset while lose=1 and count=3 -> immediately lose=0, count=0, enemy_x=START_X, alive=all ones. enable=0 for 10 ticks -> no change.

Source files
------------

// File: rtl/enemy_walker_array_if.sv
// Bundle between the walker array, the tile/background store and the game-state consumers.
// Master drives the map, Mario and enemy heights; slave returns positions, liveness and status.
interface enemy_walker_array_if #(
  parameter int NUM_ENEMIES = 4,
  parameter int COUNT_W     = 8
);
  logic                     enable;
  logic [11:0][16:0][7:0]   background;
  int                       mario_x;
  int                       mario_y;
  int                       enemy_y [NUM_ENEMIES];
  int                       enemy_x [NUM_ENEMIES];
  logic [NUM_ENEMIES-1:0]   enemy_alive;
  logic                     lose;
  logic [COUNT_W-1:0]       stomp_count;

  modport master (
    output enable, background, mario_x, mario_y, enemy_y,
    input  enemy_x, enemy_alive, lose, stomp_count
  );

  modport slave (
    input  enable, background, mario_x, mario_y, enemy_y,
    output enemy_x, enemy_alive, lose, stomp_count
  );
endinterface

// File: rtl/enemy_walker_array.sv
// Array of independent goomba-class walkers: patrol left/right on the tile map, die when
// stomped from above, and latch a global lose flag on side contact with Mario.
module enemy_walker_array #(
  parameter int                     NUM_ENEMIES     = 4,
  parameter int                     CHARACTER_WIDTH = 42,
  parameter int                     SCREEN_WIDTH    = 640,
  parameter int                     BLOCK_WIDTH     = 40,
  parameter int                     SPEED           = 1,
  parameter logic [7:0]             BLK             = 8'd2,
  parameter int                     START_X [NUM_ENEMIES] = '{300, 100, 500, 200},
  parameter logic [NUM_ENEMIES-1:0] START_DIR       = 4'b0101,
  parameter int                     OFFSCREEN_X     = 1000,
  parameter int                     COUNT_W         = 8
) (
  input logic                  movement_clock,
  input logic                  reset,
  enemy_walker_array_if.slave  bus
);

  localparam int W = CHARACTER_WIDTH;
  localparam logic [COUNT_W:0] CountMax = {1'b0, {COUNT_W{1'b1}}};

  typedef enum logic [1:0] {StWalkL, StWalkR, StDead} state_e;

  state_e                 state_q [NUM_ENEMIES];
  state_e                 state_d [NUM_ENEMIES];
  int                     x_q     [NUM_ENEMIES];
  int                     x_d     [NUM_ENEMIES];
  logic                   lose_q, lose_d;
  logic [COUNT_W-1:0]     count_q, count_d;
  logic [COUNT_W:0]       stomp_n;
  logic [COUNT_W:0]       count_sum;
  logic [NUM_ENEMIES-1:0] stomp, touch, blk_l, blk_r;

  // Tiles outside the 12x17 map never block.
  function automatic logic tile_blk(input logic [11:0][16:0][7:0] bg, input int r, input int c);
    logic hit;
    hit = 1'b0;
    if (r >= 0 && r <= 11 && c >= 0 && c <= 16) hit = (bg[r[3:0]][c[4:0]] == BLK);
    return hit;
  endfunction

  for (genvar g = 0; g < NUM_ENEMIES; g++) begin : g_ch
    int   ex, ey, rt, rb, cl, cr;
    logic hov;

    assign ex  = x_q[g];
    assign ey  = bus.enemy_y[g];
    assign rt  = ey / BLOCK_WIDTH;
    assign rb  = (ey + W - 1) / BLOCK_WIDTH;
    assign cl  = (ex - SPEED) / BLOCK_WIDTH;
    assign cr  = (ex + W - 1 + SPEED) / BLOCK_WIDTH;
    assign hov = (bus.mario_x + W > ex) && (bus.mario_x < ex + W);

    assign stomp[g] = hov && (bus.mario_y + W == ey);
    assign touch[g] = hov && (bus.mario_y + W > ey) && (bus.mario_y < ey + W);
    // Screen-edge terms come first so the map is only consulted for in-range columns.
    assign blk_l[g] = (ex < SPEED) ||
                      tile_blk(bus.background, rt, cl) || tile_blk(bus.background, rb, cl);
    assign blk_r[g] = (ex + W + SPEED > SCREEN_WIDTH) ||
                      tile_blk(bus.background, rt, cr) || tile_blk(bus.background, rb, cr);

    assign bus.enemy_x[g]     = x_q[g];
    assign bus.enemy_alive[g] = (state_q[g] != StDead);
  end

  always_comb begin
    lose_d    = lose_q;
    count_d   = count_q;
    stomp_n   = '0;
    count_sum = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      state_d[i] = state_q[i];
      x_d[i]     = x_q[i];
    end
    if (bus.enable && !lose_q) begin
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        if (state_q[i] != StDead) begin
          if (stomp[i]) begin
            state_d[i] = StDead;
            x_d[i]     = OFFSCREEN_X;
            stomp_n    = stomp_n + (COUNT_W + 1)'(1);
          end else if (touch[i]) begin
            lose_d = 1'b1;
          end else if (state_q[i] == StWalkL) begin
            if (blk_l[i]) state_d[i] = StWalkR;
            else          x_d[i]     = x_q[i] - SPEED;
          end else begin
            if (blk_r[i]) state_d[i] = StWalkL;
            else          x_d[i]     = x_q[i] + SPEED;
          end
        end
      end
      count_sum = {1'b0, count_q} + stomp_n;
      count_d   = (count_sum > CountMax) ? CountMax[COUNT_W-1:0] : count_sum[COUNT_W-1:0];
    end
  end

  always_ff @(posedge movement_clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        x_q[i]     <= START_X[i];
        state_q[i] <= START_DIR[i] ? StWalkR : StWalkL;
      end
      lose_q  <= 1'b0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENEMIES; i++) begin
        x_q[i]     <= x_d[i];
        state_q[i] <= state_d[i];
      end
      lose_q  <= lose_d;
      count_q <= count_d;
    end
  end

  assign bus.lose        = lose_q;
  assign bus.stomp_count = count_q;

endmodule

// File: tb/tb_enemy_walker_array.sv
// Bench for enemy_walker_array: directed scenarios with literal expectations plus randomized
// play compared every cycle against a plain behavioural model of the walkers.
module tb_enemy_walker_array;
  localparam int N  = 4;
  localparam int W  = 42;
  localparam int CW = 8;
  localparam int START_X [N] = '{300, 100, 500, 200};
  localparam logic [N-1:0] START_DIR = 4'b0101;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  enemy_walker_array_if #(.NUM_ENEMIES(N), .COUNT_W(CW)) bus ();

  enemy_walker_array #(.NUM_ENEMIES(N), .COUNT_W(CW)) dut (
    .movement_clock (clk),
    .reset          (rst),
    .bus            (bus)
  );

  int m_x     [N];
  bit m_right [N];
  bit m_alive [N];
  bit m_lose;
  int m_count;
  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_x[i]     = START_X[i];
      m_right[i] = START_DIR[i];
      m_alive[i] = 1'b1;
    end
    m_lose  = 1'b0;
    m_count = 0;
  endtask

  function automatic bit is_block(input int r, input int c);
    if (r < 0 || r > 11 || c < 0 || c > 16) return 1'b0;
    return bus.background[r][c] == 8'd2;
  endfunction

  task automatic model_step();
    int nx [N];
    bit nr [N];
    bit na [N];
    bit nl;
    int k, ex, ey;
    bit over, wall;
    if (!bus.enable || m_lose) return;
    nl = 1'b0;
    k  = 0;
    for (int i = 0; i < N; i++) begin
      nx[i] = m_x[i];
      nr[i] = m_right[i];
      na[i] = m_alive[i];
      if (m_alive[i]) begin
        ex   = m_x[i];
        ey   = bus.enemy_y[i];
        over = (bus.mario_x + W > ex) && (bus.mario_x < ex + W);
        if (over && bus.mario_y + W == ey) begin
          na[i] = 1'b0;
          nx[i] = 1000;
          k++;
        end else if (over && bus.mario_y + W > ey && bus.mario_y < ey + W) begin
          nl = 1'b1;
        end else if (!m_right[i]) begin
          wall = (ex < 1) || is_block(ey / 40, (ex - 1) / 40) ||
                 is_block((ey + W - 1) / 40, (ex - 1) / 40);
          if (wall) nr[i] = 1'b1;
          else      nx[i] = ex - 1;
        end else begin
          wall = (ex + W + 1 > 640) || is_block(ey / 40, (ex + W) / 40) ||
                 is_block((ey + W - 1) / 40, (ex + W) / 40);
          if (wall) nr[i] = 1'b0;
          else      nx[i] = ex + 1;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      m_x[i]     = nx[i];
      m_right[i] = nr[i];
      m_alive[i] = na[i];
    end
    m_lose  = nl;
    m_count = (m_count + k > 255) ? 255 : m_count + k;
  endtask

  always @(posedge clk) if (rst) model_step();

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("cyc_x%0d", i), bus.enemy_x[i], m_x[i]);
        check($sformatf("cyc_alive%0d", i), {31'd0, bus.enemy_alive[i]}, {31'd0, m_alive[i]});
      end
      check("cyc_lose", {31'd0, bus.lose}, {31'd0, m_lose});
      check("cyc_count", {24'd0, bus.stomp_count}, m_count);
    end
  end

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < N; i++) check($sformatf("%s_x%0d", tag, i), bus.enemy_x[i], START_X[i]);
    check({tag, "_alive"}, {28'd0, bus.enemy_alive}, 32'hf);
    check({tag, "_lose"}, {31'd0, bus.lose}, 0);
    check({tag, "_count"}, {24'd0, bus.stomp_count}, 0);
  endtask

  // Reset asserted mid-cycle so the asynchronous path is what clears state.
  task automatic apply_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check_reset_vals("rst");
    #3;
    rst = 1'b1;
  endtask

  task automatic set_ey(input int v);
    for (int i = 0; i < N; i++) bus.enemy_y[i] = v;
  endtask

  task automatic mario(input int x, input int y);
    bus.mario_x = x;
    bus.mario_y = y;
  endtask

  initial begin
    int j, sel;
    rst            = 1'b0;
    bus.enable     = 1'b1;
    bus.background = '0;
    mario(0, 0);
    set_ey(400);
    model_reset();
    #7;
    rst    = 1'b1;
    cmp_on = 1'b1;

    // Free walking, Mario far away.
    apply_reset();
    ticks(5);
    check("walk_x0", bus.enemy_x[0], 305);
    check("walk_x1", bus.enemy_x[1], 95);

    // Block column 9 in rows 10/11 stops ch0 at 318.
    apply_reset();
    bus.background[10][9] = 8'd2;
    bus.background[11][9] = 8'd2;
    ticks(18);
    check("blk_reach", bus.enemy_x[0], 318);
    ticks(1);
    check("blk_hold", bus.enemy_x[0], 318);
    ticks(1);
    check("blk_back1", bus.enemy_x[0], 317);
    ticks(1);
    check("blk_back2", bus.enemy_x[0], 316);

    // Left screen edge for ch1.
    bus.background = '0;
    apply_reset();
    ticks(98);
    check("edge_x2", bus.enemy_x[1], 2);
    ticks(1);
    check("edge_x1", bus.enemy_x[1], 1);
    ticks(1);
    check("edge_x0", bus.enemy_x[1], 0);
    ticks(1);
    check("edge_hold", bus.enemy_x[1], 0);
    ticks(1);
    check("edge_turn", bus.enemy_x[1], 1);

    // Stomp on ch0.
    apply_reset();
    mario(280, 358);
    ticks(1);
    check("stomp_alive0", {31'd0, bus.enemy_alive[0]}, 0);
    check("stomp_x0", bus.enemy_x[0], 1000);
    check("stomp_count", {24'd0, bus.stomp_count}, 1);
    check("stomp_lose", {31'd0, bus.lose}, 0);
    check("stomp_x1", bus.enemy_x[1], 99);
    check("stomp_x2", bus.enemy_x[2], 501);

    // Side touch latches lose and freezes everything.
    apply_reset();
    mario(280, 380);
    ticks(1);
    check("touch_lose", {31'd0, bus.lose}, 1);
    check("touch_x0", bus.enemy_x[0], 300);
    check("touch_x1", bus.enemy_x[1], 99);
    mario(280, 358);
    ticks(3);
    check("frz_count", {24'd0, bus.stomp_count}, 0);
    check("frz_alive0", {31'd0, bus.enemy_alive[0]}, 1);
    check("frz_x1", bus.enemy_x[1], 99);
    check("frz_x2", bus.enemy_x[2], 501);

    // Three stomps, then a touch, then reset and a disabled hold.
    apply_reset();
    mario(280, 358);
    ticks(1);
    mario(180, 358);
    ticks(1);
    mario(80, 358);
    ticks(1);
    check("seq_count3", {24'd0, bus.stomp_count}, 3);
    mario(490, 380);
    ticks(1);
    check("seq_lose", {31'd0, bus.lose}, 1);
    check("seq_alive", {28'd0, bus.enemy_alive}, 32'h4);
    mario(0, 0);
    apply_reset();
    bus.enable = 1'b0;
    ticks(10);
    check_reset_vals("hold");
    bus.enable = 1'b1;

    // Randomized play on random maps.
    for (int ep = 0; ep < 25; ep++) begin
      bus.background = '0;
      for (int b = 0; b < 25; b++)
        bus.background[$urandom_range(0, 11)][$urandom_range(0, 16)] = 8'($urandom_range(1, 3));
      for (int i = 0; i < N; i++) bus.enemy_y[i] = int'($urandom_range(0, 460));
      mario(0, -200);
      apply_reset();
      for (int t = 0; t < 80; t++) begin
        bus.enable = ($urandom_range(0, 9) != 0);
        j   = int'($urandom_range(0, N - 1));
        sel = int'($urandom_range(0, 15));
        bus.mario_x = m_x[j] + int'($urandom_range(0, 100)) - 60;
        if (sel < 4)       bus.mario_y = bus.enemy_y[j] - W;
        else if (sel == 4) bus.mario_y = bus.enemy_y[j] - int'($urandom_range(0, 30));
        else               bus.mario_y = -200;
        ticks(1);
      end
    end

    @(negedge clk);
    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
